// File: rtl/board_rand_if.sv
// Selector <-> board generator bus: fill request, board geometry and the
// board-memory write port.
interface board_rand_if;
    logic       INITIALIZE_BOARD;
    logic [4:0] final_SIZE;
    logic [3:0] final_COLOR_NUM;
    logic       BOARD_READY;
    logic       WR_EN;
    logic [9:0] WR_ADDR;
    logic [2:0] WR_COLOR;
    logic [2:0] ORIGIN_COLOR;

    modport master (
        output INITIALIZE_BOARD, final_SIZE, final_COLOR_NUM,
        input  BOARD_READY, WR_EN, WR_ADDR, WR_COLOR, ORIGIN_COLOR
    );

    modport slave (
        input  INITIALIZE_BOARD, final_SIZE, final_COLOR_NUM,
        output BOARD_READY, WR_EN, WR_ADDR, WR_COLOR, ORIGIN_COLOR
    );
endinterface

// File: rtl/board_rand.sv
// Random board generator: fills size x size cells with uniform colours drawn
// from a free-running LFSR, then acknowledges with BOARD_READY.
module board_rand #(
    parameter int          MAX_SIZE = 26,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic         MASTER_CLOCK,
    input  logic         RESET_N,
    board_rand_if.slave  bus
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [4:0]  MAX_SZ   = 5'(MAX_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  size_q, size_d;
    logic [3:0]  ncol_q, ncol_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic        wr_en_q, wr_en_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [2:0]  wr_color_q, wr_color_d;
    logic        ready_q, ready_d;
    logic [2:0]  shadow_q, shadow_d;
    logic [2:0]  origin_q, origin_d;
    logic [2:0]  cand_s;
    logic        accept_s;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v[0]) begin
            return (v >> 1) ^ 16'hB400;
        end else begin
            return v >> 1;
        end
    endfunction

    function automatic logic [4:0] clamp_size(input logic [4:0] s);
        if (s < 5'd2) begin
            return 5'd2;
        end else if (s > MAX_SZ) begin
            return MAX_SZ;
        end else begin
            return s;
        end
    endfunction

    function automatic logic [3:0] clamp_ncol(input logic [3:0] c);
        if ((c < 4'd3) || (c > 4'd8)) begin
            return 4'd6;
        end else begin
            return c;
        end
    endfunction

    // Rejection sampling keeps accepted colours uniform over 0..ncol-1.
    assign cand_s   = lfsr_q[2:0];
    assign accept_s = ({1'b0, cand_s} < ncol_q);

    // Next-state, fill walk and registered output computation.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_step(lfsr_q);
        size_d     = size_q;
        ncol_d     = ncol_q;
        row_d      = row_q;
        col_d      = col_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_color_d = wr_color_q;
        ready_d    = 1'b0;
        shadow_d   = shadow_q;
        origin_d   = origin_q;
        case (state_q)
            IDLE: begin
                if (bus.INITIALIZE_BOARD) begin
                    size_d  = clamp_size(bus.final_SIZE);
                    ncol_d  = clamp_ncol(bus.final_COLOR_NUM);
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (!bus.INITIALIZE_BOARD) begin
                    state_d = IDLE;
                end else if (accept_s) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = {row_q, col_q};
                    wr_color_d = cand_s;
                    if ((row_q == 5'd0) && (col_q == 5'd0)) begin
                        shadow_d = cand_s;
                    end else begin
                        shadow_d = shadow_q;
                    end
                    if (col_q == (size_q - 5'd1)) begin
                        col_d = 5'd0;
                        if (row_q == (size_q - 5'd1)) begin
                            state_d  = DONE;
                            origin_d = shadow_q;
                        end else begin
                            row_d = row_q + 5'd1;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            DONE: begin
                if (bus.INITIALIZE_BOARD) begin
                    ready_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_EFF;
            size_q     <= 5'd2;
            ncol_q     <= 4'd6;
            row_q      <= 5'd0;
            col_q      <= 5'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 10'd0;
            wr_color_q <= 3'd0;
            ready_q    <= 1'b0;
            shadow_q   <= 3'd0;
            origin_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            size_q     <= size_d;
            ncol_q     <= ncol_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_color_q <= wr_color_d;
            ready_q    <= ready_d;
            shadow_q   <= shadow_d;
            origin_q   <= origin_d;
        end
    end

    assign bus.BOARD_READY  = ready_q;
    assign bus.WR_EN        = wr_en_q;
    assign bus.WR_ADDR      = wr_addr_q;
    assign bus.WR_COLOR     = wr_color_q;
    assign bus.ORIGIN_COLOR = origin_q;

endmodule

// File: tb/tb_board_rand.sv
// Randomized bench for board_rand: an LFSR history plus raster-order model
// predicts every write, its cycle, and the handshake timing.
module tb_board_rand;

    logic clk = 1'b0;
    logic rst_n;
    board_rand_if bif ();

    board_rand dut (
        .MASTER_CLOCK (clk),
        .RESET_N      (rst_n),
        .bus          (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Model LFSR value seen by the DUT at each counted rising edge.
    logic [15:0] m_lfsr;
    logic [15:0] lfsr_hist [0:65535];
    int          cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
        end else begin
            lfsr_hist[cyc] <= m_lfsr;
            m_lfsr         <= lfsr_next(m_lfsr);
            cyc            <= cyc + 1;
        end
    end

    // Write / ready monitor, sampled on the falling edge.
    int ob_edge [$];
    int ob_addr [$];
    int ob_col  [$];
    int rdy_edge = -1;
    logic rdy_prev = 1'b0;

    always @(negedge clk) begin
        if (bif.WR_EN === 1'b1) begin
            ob_edge.push_back(cyc - 1);
            ob_addr.push_back(int'(bif.WR_ADDR));
            ob_col.push_back(int'(bif.WR_COLOR));
        end
        if ((bif.BOARD_READY === 1'b1) && !rdy_prev) rdy_edge = cyc - 1;
        rdy_prev = (bif.BOARD_READY === 1'b1);
    end

    int col_hist [0:7];
    int max_col;
    int saved_origin;

    task automatic run_fill(input int size_in, input int nc_in, input int sz, input int nc, input string tag);
        int start, waited, e, n, bad, nmin;
        int ex_edge [$];
        int ex_addr [$];
        int ex_col  [$];
        bit seen [0:1023];
        ob_edge.delete(); ob_addr.delete(); ob_col.delete();
        rdy_edge = -1;
        @(negedge clk); #1;
        bif.final_SIZE       = 5'(size_in);
        bif.final_COLOR_NUM  = 4'(nc_in);
        bif.INITIALIZE_BOARD = 1'b1;
        start = cyc;
        waited = 0;
        while ((bif.BOARD_READY !== 1'b1) && (waited < 20000)) begin
            @(negedge clk); #1;
            waited++;
        end
        check_val({tag, "_ready_seen"}, int'(waited < 20000), 1);
        e = start + 1;
        n = 0;
        while ((n < sz * sz) && (e < cyc)) begin
            if (int'(lfsr_hist[e][2:0]) < nc) begin
                ex_edge.push_back(e);
                ex_addr.push_back((n / sz) * 32 + (n % sz));
                ex_col.push_back(int'(lfsr_hist[e][2:0]));
                n++;
            end
            e++;
        end
        check_val({tag, "_nwrites"}, ob_edge.size(), sz * sz);
        nmin = (ob_edge.size() < ex_edge.size()) ? ob_edge.size() : ex_edge.size();
        for (int i = 0; i < nmin; i++) begin
            check_val({tag, "_wr_cycle"}, ob_edge[i], ex_edge[i]);
            check_val({tag, "_wr_addr"}, ob_addr[i], ex_addr[i]);
            check_val({tag, "_wr_color"}, ob_col[i], ex_col[i]);
        end
        if (ex_edge.size() > 0) begin
            check_val({tag, "_ready_edge"}, rdy_edge, ex_edge[ex_edge.size() - 1] + 1);
            check_val({tag, "_origin"}, int'(bif.ORIGIN_COLOR), ex_col[0]);
        end
        bad = 0;
        max_col = 0;
        for (int c = 0; c < 8; c++) col_hist[c] = 0;
        for (int a = 0; a < 1024; a++) seen[a] = 1'b0;
        foreach (ob_addr[i]) begin
            if (((ob_addr[i] % 32) >= sz) || ((ob_addr[i] / 32) >= sz) || seen[ob_addr[i]]) bad++;
            seen[ob_addr[i]] = 1'b1;
            col_hist[ob_col[i]]++;
            if (ob_col[i] > max_col) max_col = ob_col[i];
        end
        check_val({tag, "_addr_range_dup"}, bad, 0);
    endtask

    task automatic release_init(input string tag);
        @(negedge clk); #1;
        bif.INITIALIZE_BOARD = 1'b0;
        @(negedge clk); #1;
        check_val({tag, "_ready_fall"}, int'(bif.BOARD_READY), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_ready"}, int'(bif.BOARD_READY), 0);
        check_val({tag, "_wr_en"}, int'(bif.WR_EN), 0);
        check_val({tag, "_wr_addr"}, int'(bif.WR_ADDR), 0);
        check_val({tag, "_wr_color"}, int'(bif.WR_COLOR), 0);
        check_val({tag, "_origin"}, int'(bif.ORIGIN_COLOR), 0);
    endtask

    initial begin
        int w, n0;
        rst_n = 1'b0;
        bif.INITIALIZE_BOARD = 1'b0;
        bif.final_SIZE       = 5'd0;
        bif.final_COLOR_NUM  = 4'd0;
        #23;
        check_outputs_zero("reset");
        repeat ($urandom_range(5, 1)) @(negedge clk);
        rst_n = 1'b1;
        repeat ($urandom_range(20, 1)) @(negedge clk);

        // Smallest board, no rejection, then hold the handshake.
        run_fill(2, 8, 2, 8, "s2c8");
        n0 = ob_edge.size();
        repeat (5) @(negedge clk);
        #1;
        check_val("hold_ready", int'(bif.BOARD_READY), 1);
        check_val("hold_no_writes", ob_edge.size(), n0);
        release_init("s2c8");
        repeat ($urandom_range(30, 1)) @(negedge clk);

        // Largest board with heavy rejection.
        run_fill(26, 3, 26, 3, "s26c3");
        check_val("s26c3_max_color", int'(max_col <= 2), 1);
        for (int c = 0; c < 3; c++)
            check_val("s26c3_hist", int'((col_hist[c] >= 191) && (col_hist[c] <= 259)), 1);
        saved_origin = int'(bif.ORIGIN_COLOR);
        release_init("s26c3");
        repeat ($urandom_range(30, 1)) @(negedge clk);

        // Abort after 10 writes of a 14x14 board.
        ob_edge.delete(); ob_addr.delete(); ob_col.delete();
        rdy_edge = -1;
        @(negedge clk); #1;
        bif.final_SIZE       = 5'd14;
        bif.final_COLOR_NUM  = 4'd5;
        bif.INITIALIZE_BOARD = 1'b1;
        w = 0;
        while ((ob_edge.size() < 10) && (w < 5000)) begin
            @(negedge clk); #1;
            w++;
        end
        check_val("abort_reached_10", int'(w < 5000), 1);
        bif.INITIALIZE_BOARD = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_val("abort_nwrites", ob_edge.size(), 10);
        check_val("abort_no_ready", rdy_edge, -1);
        check_val("abort_origin_kept", int'(bif.ORIGIN_COLOR), saved_origin);

        // Asynchronous reset in the middle of a fill.
        @(negedge clk); #1;
        bif.final_SIZE       = 5'd10;
        bif.final_COLOR_NUM  = 4'd8;
        bif.INITIALIZE_BOARD = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        bif.INITIALIZE_BOARD = 1'b0;
        #1;
        check_outputs_zero("midfill_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_fill(2, 8, 2, 8, "post_reset");
        release_init("post_reset");
        repeat ($urandom_range(30, 1)) @(negedge clk);

        // Out-of-range inputs fall back to 26x26 with 6 colours.
        run_fill(31, 1, 26, 6, "illegal");
        check_val("illegal_max_color", int'(max_col <= 5), 1);
        release_init("illegal");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
